// File: rtl/move_scheduler.sv
// Frame-synchronous movement controller: latches per-object move commands from UART bytes
// and applies them to a 15-object position table in one sequential scan per frame tick.
module move_scheduler #(
   parameter int unsigned STEP  = 1,
   parameter int unsigned X_MIN = 40,
   parameter int unsigned X_MAX = 760,
   parameter int unsigned Y_MIN = 84,
   parameter int unsigned Y_MAX = 516,
   parameter int unsigned X_RST = 400,
   parameter int unsigned Y_RST = 300
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        frame_tick,
   input  logic [3:0]  rd_idx,
   output logic [10:0] rd_x,
   output logic [9:0]  rd_y,
   output logic        busy,
   output logic        update_done,
   output logic        overrun
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam int unsigned N_OBJ = 15;

   state_t      state_q, state_d;
   logic [3:0]  scan_idx_q, scan_idx_d;
   logic [3:0]  pending_q [N_OBJ];
   logic [3:0]  pending_d [N_OBJ];
   logic [10:0] pos_x_q [N_OBJ];
   logic [10:0] pos_x_d [N_OBJ];
   logic [9:0]  pos_y_q [N_OBJ];
   logic [9:0]  pos_y_d [N_OBJ];
   logic [10:0] rd_x_q, rd_x_d;
   logic [9:0]  rd_y_q, rd_y_d;
   logic        overrun_q, overrun_d;
   logic [11:0] nx, ny;
   logic [3:0]  rx_idx;

   // Signed step then clamp; a pending +/- pair cancels to no movement.
   function automatic logic [11:0] step_axis(input logic [11:0] p, input logic inc,
                                             input logic dec, input logic [11:0] lo,
                                             input logic [11:0] hi);
      logic signed [11:0] n;
      n = $signed(p);
      if (inc && !dec)      n = n + $signed(12'(STEP));
      else if (dec && !inc) n = n - $signed(12'(STEP));
      if (n < $signed(lo))      n = $signed(lo);
      else if (n > $signed(hi)) n = $signed(hi);
      return n;
   endfunction

   assign rx_idx = rx_data[7:4];

   always_comb begin
      state_d    = state_q;
      scan_idx_d = scan_idx_q;
      overrun_d  = overrun_q;
      nx         = '0;
      ny         = '0;
      rd_x_d     = 11'(X_RST);
      rd_y_d     = 10'(Y_RST);
      for (int unsigned i = 0; i < N_OBJ; i++) begin
         pending_d[i] = pending_q[i];
         pos_x_d[i]   = pos_x_q[i];
         pos_y_d[i]   = pos_y_q[i];
      end

      for (int unsigned i = 0; i < N_OBJ; i++) begin
         if (state_q == S_SCAN && scan_idx_q == 4'(i)) begin
            nx = step_axis({1'b0, pos_x_q[i]}, pending_q[i][0], pending_q[i][1],
                           12'(X_MIN), 12'(X_MAX));
            ny = step_axis({2'b00, pos_y_q[i]}, pending_q[i][2], pending_q[i][3],
                           12'(Y_MIN), 12'(Y_MAX));
            pos_x_d[i]   = 11'(nx);
            pos_y_d[i]   = 10'(ny);
            pending_d[i] = '0;
         end
         // Written after the scan clear so a same-cycle command survives for the next frame.
         if (rx_valid && rx_idx == 4'(i))
            pending_d[i] = rx_data[3:0];
         if (rd_idx == 4'(i)) begin
            rd_x_d = pos_x_q[i];
            rd_y_d = pos_y_q[i];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (frame_tick) begin
               state_d    = S_SCAN;
               scan_idx_d = '0;
            end
         end
         S_SCAN: begin
            if (frame_tick) overrun_d = 1'b1;
            if (scan_idx_q == 4'(N_OBJ - 1)) state_d = S_DONE;
            else scan_idx_d = scan_idx_q + 4'd1;
         end
         S_DONE: begin
            if (frame_tick) overrun_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         scan_idx_q <= '0;
         overrun_q  <= 1'b0;
         rd_x_q     <= 11'(X_RST);
         rd_y_q     <= 10'(Y_RST);
         for (int unsigned i = 0; i < N_OBJ; i++) begin
            pending_q[i] <= '0;
            pos_x_q[i]   <= 11'(X_RST);
            pos_y_q[i]   <= 10'(Y_RST);
         end
      end else begin
         state_q    <= state_d;
         scan_idx_q <= scan_idx_d;
         overrun_q  <= overrun_d;
         rd_x_q     <= rd_x_d;
         rd_y_q     <= rd_y_d;
         for (int unsigned i = 0; i < N_OBJ; i++) begin
            pending_q[i] <= pending_d[i];
            pos_x_q[i]   <= pos_x_d[i];
            pos_y_q[i]   <= pos_y_d[i];
         end
      end
   end

   assign rd_x        = rd_x_q;
   assign rd_y        = rd_y_q;
   assign busy        = (state_q == S_SCAN);
   assign update_done = (state_q == S_DONE);
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Randomised and directed bench for move_scheduler, checked every cycle against a
// table-level behavioural model of the frame scan.
module tb_move_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        frame_tick = 1'b0;
   logic [3:0]  rd_idx = '0;
   logic [10:0] rd_x;
   logic [9:0]  rd_y;
   logic        busy, update_done, overrun;

   move_scheduler #(.STEP(1), .X_MIN(40), .X_MAX(760), .Y_MIN(84), .Y_MAX(516),
                    .X_RST(400), .Y_RST(300)) dut (
      .CLOCK_50(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_tick(frame_tick), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
      .busy(busy), .update_done(update_done), .overrun(overrun));

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Model: object table plus a frame phase (-1 idle, 0..14 entry being scanned, 15 done).
   int       mx [16];
   int       my [16];
   bit [3:0] mp [16];
   int       phase;
   int       e_rdx, e_rdy;
   bit       e_ovr;

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic int delta(input bit plus, input bit minus);
      return (plus && !minus) ? 1 : (minus && !plus) ? -1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            mx[i] = 400; my[i] = 300; mp[i] = '0;
         end
         phase = -1; e_rdx = 400; e_rdy = 300; e_ovr = 1'b0;
      end else begin
         e_rdx = (rd_idx == 4'd15) ? 400 : mx[rd_idx];
         e_rdy = (rd_idx == 4'd15) ? 300 : my[rd_idx];
         if (phase >= 0 && phase <= 14) begin
            mx[phase] = clampi(mx[phase] + delta(mp[phase][0], mp[phase][1]), 40, 760);
            my[phase] = clampi(my[phase] + delta(mp[phase][2], mp[phase][3]), 84, 516);
            mp[phase] = '0;
         end
         if (rx_valid && rx_data[7:4] != 4'd15) mp[rx_data[7:4]] = rx_data[3:0];
         if (frame_tick && phase != -1) e_ovr = 1'b1;
         if (phase == -1) phase = frame_tick ? 0 : -1;
         else if (phase == 15) phase = -1;
         else phase = phase + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rd_x", int'(rd_x), e_rdx);
         chk("rd_y", int'(rd_y), e_rdy);
         chk("busy", int'(busy), (phase >= 0 && phase <= 14) ? 1 : 0);
         chk("update_done", int'(update_done), (phase == 15) ? 1 : 0);
         chk("overrun", int'(overrun), int'(e_ovr));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
   endtask

   task automatic wait_done(output int nbusy);
      bit seen = 1'b0;
      nbusy = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (update_done) seen = 1'b1;
      end
      chk("scan_completes", int'(seen), 1);
      step(1);
   endtask

   task automatic frame();
      int nb;
      tick();
      wait_done(nb);
   endtask

   task automatic read_obj(input logic [3:0] idx, input int ex, input int ey, input string nm);
      rd_idx = idx;
      step(1);
      chk({nm, "_x"}, int'(rd_x), ex);
      chk({nm, "_y"}, int'(rd_y), ey);
   endtask

   initial begin
      int nb;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      rd_idx = 4'd3;
      #20 rst_n = 1'b1;
      step(1);
      chk("reset_rd_x", int'(rd_x), 400);
      chk("reset_rd_y", int'(rd_y), 300);
      chk("reset_busy", int'(busy), 0);
      chk("reset_overrun", int'(overrun), 0);

      send(8'h05);
      tick();
      wait_done(nb);
      chk("busy_cycles", nb, 15);
      read_obj(4'd0, 401, 301, "obj0_step");
      frame();
      read_obj(4'd0, 401, 301, "obj0_hold");

      send(8'hF1);
      frame();
      read_obj(4'd15, 400, 300, "idx15");
      send(8'h73);
      frame();
      read_obj(4'd7, 400, 300, "ball_cancel");

      for (int i = 0; i < 365; i++) begin
         send(8'h81);
         frame();
      end
      read_obj(4'd8, 760, 300, "obj8_xmax");
      for (int i = 0; i < 220; i++) begin
         send(8'h88);
         frame();
      end
      read_obj(4'd8, 760, 84, "obj8_ymin");

      send(8'h24);
      tick();
      step(2);
      rx_data = 8'h21; rx_valid = 1'b1; frame_tick = 1'b1;
      step(1);
      rx_valid = 1'b0; frame_tick = 1'b0;
      wait_done(nb);
      read_obj(4'd2, 400, 301, "obj2_old_cmd");
      chk("overrun_set", int'(overrun), 1);
      frame();
      read_obj(4'd2, 401, 301, "obj2_new_cmd");
      chk("overrun_sticky", int'(overrun), 1);

      send(8'h09);
      send(8'h5A);
      send(8'h96);
      tick();
      step(7);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", int'(busy), 0);
      chk("async_done", int'(update_done), 0);
      chk("async_overrun", int'(overrun), 0);
      chk("async_rd_x", int'(rd_x), 400);
      #10 rst_n = 1'b1;
      step(25);
      for (int i = 0; i < 16; i++) read_obj(4'(i), 400, 300, "post_reset");

      for (int c = 0; c < 3000; c++) begin
         rx_valid   = ($urandom_range(0, 2) == 0);
         rx_data    = 8'($urandom);
         frame_tick = ($urandom_range(0, 24) == 0);
         rd_idx     = 4'($urandom);
         step(1);
      end
      rx_valid = 1'b0; frame_tick = 1'b0;
      step(20);
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         step(1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
